// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register addresses, transmitter FSM state type, STATUS bit positions
//   and a helper that saturates the FIFO occupancy to the 4-bit STATUS field.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [31:0] UART_TXDATA_ADDR = 32'h0000_0400;
   localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0404;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   // STATUS = {24'b0, count[3:0], overflow, busy, empty, full}
   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_CNT_LSB   = 4;
   localparam int STAT_CNT_MSB   = 7;

   // Writing 1 to this STATUS bit clears the sticky overflow flag.
   localparam int STAT_OVF_CLR_BIT = 3;

   // FIFO occupancy can exceed what the 4-bit STATUS field holds when the
   // FIFO is deep; report 15 in that case.
   function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
      if (cnt > 32'd15) begin
         return 4'hF;
      end
      return cnt[3:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. dout always shows the head
//   entry, so a consumer can capture dout in the same cycle it asserts pop.
//
//   Ports
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-high reset (pointers and count only)
//     push   in   write din; accepted when not full, or when full and a pop
//                 is accepted in the same cycle
//     pop    in   discard head entry; ignored when empty
//     din    in   WIDTH-bit write data
//     dout   out  WIDTH-bit head entry
//     full   out  count == DEPTH
//     empty  out  count == 0
//     count  out  number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // A full FIFO still takes a write when the head leaves in the same cycle.
      do_push  = push && ((count_q != FULL_COUNT) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: clearing the pointers and count already discards
   // every entry.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue a byte in a
//   small FIFO; the FSM drains it onto tx LSB first, one start bit, eight data
//   bits, one stop bit, each CLKS_PER_BIT clocks long. Queued bytes go out
//   back to back with no idle gap. STATUS reports FIFO state, busy and a
//   sticky overflow flag that is cleared by writing 1 to STATUS bit 3.
//
//   Ports
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-high reset
//     MemWrite   in   one-cycle store strobe
//     DataAdr    in   32-bit byte address of the load/store
//     WriteData  in   32-bit store data (byte in [7:0])
//     ReadData   out  combinational read data for DataAdr (0 if unmapped)
//     sel        out  combinational, DataAdr hits TXDATA or STATUS
//     tx         out  registered serial line, idle high
//     busy       out  FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        sel,
   output logic        tx,
   output logic        busy
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   logic             hit_txdata, hit_status, wr_txdata, wr_status;
   logic             fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic [31:0]      status_word;
   logic             ovf_set, ovf_clr, bit_end;

   uart_tx_state_t   state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             overflow_q, overflow_d;

   logic             unused_wdata;
   assign unused_wdata = ^WriteData[31:8];

   // Address decode
   assign hit_txdata = (DataAdr == UART_TXDATA_ADDR);
   assign hit_status = (DataAdr == UART_STATUS_ADDR);
   assign sel        = hit_txdata || hit_status;
   assign wr_txdata  = MemWrite && hit_txdata;
   assign wr_status  = MemWrite && hit_status;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Transmitter FSM. tx_d is the line level for the cycle after the edge,
   // so tx comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      baud_d   = '0;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      fifo_pop = 1'b0;
      bit_end  = (baud_q == BAUD_LAST);
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               state_d  = START;
               tx_d     = 1'b0;
            end
         end
         START: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
            tx_d   = 1'b0;
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
            tx_d   = shift_q[0];
            if (bit_end) begin
               // The 3-bit index wraps 7 -> 0, ready for the next frame.
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               tx_d    = shift_q[1];
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end
            end
         end
         STOP: begin
            baud_d = bit_end ? '0 : baud_q + BAUD_ONE;
            if (bit_end) begin
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
                  tx_d     = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A dropped byte sets overflow even if software clears it in the same cycle.
   always_comb begin
      ovf_set    = wr_txdata && fifo_full && !fifo_pop;
      ovf_clr    = wr_status && WriteData[STAT_OVF_CLR_BIT];
      overflow_d = overflow_q;
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE) || !fifo_empty;

   // Register read mux; TXDATA and unmapped addresses read as zero.
   always_comb begin
      status_word                             = '0;
      status_word[STAT_FULL_BIT]              = fifo_full;
      status_word[STAT_EMPTY_BIT]             = fifo_empty;
      status_word[STAT_BUSY_BIT]              = busy;
      status_word[STAT_OVF_BIT]               = overflow_q;
      status_word[STAT_CNT_MSB:STAT_CNT_LSB]  = sat_count4(32'(fifo_count));
      ReadData                                = hit_status ? status_word : '0;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). Bytes the
//   bench expects on the line are queued when stored; a line monitor captures
//   every frame cycle by cycle and compares it with the expected waveform.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] A_TX  = 32'h0000_0400;
   localparam logic [31:0] A_ST  = 32'h0000_0404;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAdr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        sel, tx, busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic [7:0] sb[$];
   int   starts[$];
   bit   in_frame = 1'b0;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .sel       (sel),
      .tx        (tx),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Expected line level for each of the FRAME cycles of a byte.
   function automatic logic [63:0] frame_wave(input logic [7:0] b);
      logic [9:0]  bits;
      logic [63:0] w;
      bits = {1'b1, b, 1'b0};
      w = '0;
      for (int i = 0; i < FRAME; i++) w[i] = bits[i / CPB];
      return w;
   endfunction

   // Line monitor: a low level while out of reset starts a frame capture.
   initial begin : monitor
      logic [63:0] wave;
      logic [7:0]  eb;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && tx === 1'b0) begin
            starts.push_back(cyc);
            in_frame = 1'b1;
            aborted = 1'b0;
            wave = '0;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge clk);
               if (reset !== 1'b0) aborted = 1'b1;
               wave[i] = tx;
            end
            if (!aborted) begin
               eb = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
               chk("frame_wave", wave, frame_wave(eb));
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      step();
      MemWrite  = 1'b0;
      DataAdr   = '0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic s);
      DataAdr  = a;
      MemWrite = 1'b0;
      #1;
      d = ReadData;
      s = sel;
   endtask

   task automatic wait_start(input int n0, input int limit, input string tag);
      int k = 0;
      while (starts.size() <= n0 && k < limit) begin
         step();
         k++;
      end
      chk(tag, 64'(starts.size() > n0), 64'd1);
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int k = 0;
      while (!(busy === 1'b0 && !in_frame && sb.size() == 0) && k < limit) begin
         step();
         k++;
      end
      chk(tag, 64'(k < limit), 64'd1);
   endtask

   initial begin : stim
      logic [31:0] rd;
      logic        s;
      int          n0, s0, c0, t, lows;

      // Reset state
      step();
      step();
      chk("rst_tx", 64'(tx), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      read_reg(A_ST, rd, s);
      chk("rst_status", 64'(rd), 64'h02);
      chk("rst_sel", 64'(s), 64'd1);
      step();

      // Single byte 0x55, stored on the first edge after reset release
      reset = 1'b0;
      n0 = starts.size();
      sb.push_back(8'h55);
      store(A_TX, 32'h0000_0055);
      c0 = cyc;
      read_reg(A_ST, rd, s);
      chk("first_push", 64'(rd), 64'h14);
      wait_start(n0, 5, "start_55");
      s0 = starts[n0];
      chk("start_latency", 64'(s0), 64'(c0 + 1));
      t = 0;
      while (busy !== 1'b0 && t < 100) begin
         step();
         t++;
      end
      chk("busy_fall", 64'(cyc), 64'(s0 + FRAME));
      wait_idle(20, "idle_55");

      // Address decode
      read_reg(32'h0000_0408, rd, s);
      chk("dec408_rd", 64'(rd), 64'h0);
      chk("dec408_sel", 64'(s), 64'd0);
      read_reg(32'h0000_0064, rd, s);
      chk("dec64_rd", 64'(rd), 64'h0);
      chk("dec64_sel", 64'(s), 64'd0);
      read_reg(A_TX, rd, s);
      chk("txdata_rd", 64'(rd), 64'h0);
      chk("txdata_sel", 64'(s), 64'd1);
      n0 = starts.size();
      store(32'h0000_0408, 32'h0000_00AA);
      store(32'h0000_0064, 32'h0000_005A);
      lows = 0;
      repeat (12) begin
         if (tx !== 1'b1) lows++;
         step();
      end
      chk("dec_tx_high", 64'(lows), 64'd0);
      read_reg(A_ST, rd, s);
      chk("dec_status", 64'(rd), 64'h02);
      chk("dec_no_frame", 64'(starts.size()), 64'(n0));

      // Back-to-back 0x41, 0x42 (0x41 leaves the FIFO on the second store edge)
      n0 = starts.size();
      sb.push_back(8'h41);
      sb.push_back(8'h42);
      store(A_TX, 32'h0000_0041);
      store(A_TX, 32'h0000_0042);
      read_reg(A_ST, rd, s);
      chk("b2b_count1", 64'(rd), 64'h14);
      wait_start(n0 + 1, 120, "b2b_second");
      if (starts.size() > n0 + 1)
         chk("b2b_gap", 64'(starts[n0+1] - starts[n0]), 64'(FRAME));
      read_reg(A_ST, rd, s);
      chk("b2b_count0", 64'(rd), 64'h06);
      wait_idle(60, "idle_b2b");

      // Overflow: 0x01 goes to the shifter, 0x02..0x05 fill the FIFO, 0x06 drops
      n0 = starts.size();
      for (int i = 1; i <= 6; i++) begin
         if (i <= 5) sb.push_back(8'(i));
         store(A_TX, 32'(i));
      end
      read_reg(A_ST, rd, s);
      chk("ovf_set", 64'(rd), 64'h4D);
      store(A_ST, 32'h0000_0008);
      read_reg(A_ST, rd, s);
      chk("ovf_clear", 64'(rd), 64'h45);

      // Full FIFO, store lands on the edge where STOP ends and the head pops
      chk("ovf_started", 64'(starts.size() > n0), 64'd1);
      s0 = (starts.size() > n0) ? starts[n0] : cyc;
      while (cyc < s0 + FRAME - 1) step();
      chk("stop_align", 64'(cyc), 64'(s0 + FRAME - 1));
      sb.push_back(8'h07);
      store(A_TX, 32'h0000_0007);
      read_reg(A_ST, rd, s);
      chk("full_pop", 64'(rd), 64'h45);
      wait_idle(5 * FRAME + 40, "idle_ovf");
      read_reg(A_ST, rd, s);
      chk("ovf_drained", 64'(rd), 64'h02);

      // Reset during data bit 3 of 0xA5
      n0 = starts.size();
      sb.push_back(8'hA5);
      store(A_TX, 32'h0000_00A5);
      wait_start(n0, 5, "start_a5");
      s0 = (starts.size() > n0) ? starts[n0] : cyc;
      while (cyc < s0 + 4 * CPB + 1) step();
      chk("a5_bit3_low", 64'(tx), 64'd0);
      reset = 1'b1;
      #1;
      chk("midrst_tx", 64'(tx), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      sb.delete();
      step();
      step();
      reset = 1'b0;
      read_reg(A_ST, rd, s);
      chk("midrst_status", 64'(rd), 64'h02);
      lows = 0;
      repeat (60) begin
         step();
         if (tx !== 1'b1) lows++;
      end
      chk("no_resume", 64'(lows), 64'd0);
      chk("no_new_frame", 64'(starts.size()), 64'(n0 + 1));

      // Recovery after reset
      n0 = starts.size();
      sb.push_back(8'h3C);
      store(A_TX, 32'h0000_003C);
      wait_start(n0, 5, "start_3c");
      wait_idle(60, "idle_3c");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
